// File: rtl/stage_if_pkg.sv
// Shared definitions for the instruction-fetch stage: exception codes, FSM
// encodings and the IF/ID bundle layout.
package stage_if_pkg;

  localparam int EC_W = 5;
  localparam logic [EC_W-1:0] EC_TLBL = 5'h02;
  localparam logic [EC_W-1:0] EC_ADEL = 5'h04;
  localparam logic [EC_W-1:0] EC_NONE = 5'h1F;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } if_state_e;

  typedef struct packed {
    logic [31:0]     instr;
    logic [31:0]     next_pc;
    logic [EC_W-1:0] exc_code;
    logic [31:0]     exc_addr;
  } if2id_t;

  localparam int IF2ID_WIRE_WIDTH = $bits(if2id_t);

  function automatic if2id_t make_entry(input logic [31:0] instr,
                                        input logic [31:0] addr,
                                        input logic [EC_W-1:0] exc_code);
    if2id_t e;
    e.instr    = instr;
    e.next_pc  = addr + 32'd4;
    e.exc_code = exc_code;
    e.exc_addr = addr;
    return e;
  endfunction

endpackage

// File: rtl/stage_if_skid_buf.sv
// One-entry holding buffer for a fetched entry that ID cannot take yet.
module if_skid_buf
  import stage_if_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   accept,
  input  logic   flush,
  input  if2id_t data_in,
  output logic   valid,
  output if2id_t data
);

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (accept) begin
      valid <= 1'b0;
    end
    if (load) begin
      data <= data_in;
    end
  end

endmodule

// File: rtl/stage_if.sv
// Instruction-fetch stage: PC, imem request/ready handshake, redirects and
// the registered IF/ID bundle.
module stage_if
  import stage_if_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'hBFC00000,
  parameter logic [31:0] BUBBLE_INSTR = 32'h00000000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  logic                        clear,
  input  logic                        branch_valid,
  input  logic [31:0]                 branch_dest,
  input  logic                        exc_redirect,
  input  logic [31:0]                 exc_redirect_pc,
  output logic                        imem_req,
  output logic [31:0]                 imem_addr,
  input  logic                        imem_ready,
  input  logic [31:0]                 imem_data,
  input  logic [EC_W-1:0]             imem_exc,
  output logic                        stall_req,
  output logic [IF2ID_WIRE_WIDTH-1:0] interstage_if2id,
  output if_state_e                   debug_state
);

  // imem handshake: a fetch completes on any cycle where imem_req and
  // imem_ready are both high; once raised, imem_req and imem_addr hold until
  // that cycle, even across redirects (the returned word is then squashed).

  if_state_e   state, state_next;
  logic [31:0] pc, pc_next, req_addr, redirect_pc;
  logic        squash, squash_next;
  logic        redirect, misaligned, fetch_done;
  logic        new_valid, avail, take, skid_load;
  logic        skid_valid;
  if2id_t      new_entry, skid_entry, head, out_q, out_next;

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .accept  (take && skid_valid),
    .flush   (redirect),
    .data_in (new_entry),
    .valid   (skid_valid),
    .data    (skid_entry)
  );

  always_comb begin
    redirect    = exc_redirect || branch_valid;
    redirect_pc = exc_redirect ? exc_redirect_pc : branch_dest;
    misaligned  = (pc[1:0] != 2'b00);
    imem_req    = rst && ((state == S_WAIT) || (state == S_REQ && !misaligned));
    imem_addr   = (state == S_WAIT) ? req_addr : pc;
    fetch_done  = imem_req && imem_ready;

    new_valid = 1'b0;
    new_entry = make_entry(BUBBLE_INSTR, pc, EC_ADEL);
    if (state == S_REQ && misaligned) begin
      new_valid = 1'b1;
    end else if (fetch_done && !squash) begin
      new_valid = 1'b1;
      new_entry = make_entry(imem_data, imem_addr, imem_exc);
    end

    // A redirect in this cycle makes every in-flight entry wrong-path.
    avail     = rst && !redirect && (skid_valid || new_valid);
    stall_req = !avail;
    take      = avail && !stall && !clear;
    skid_load = new_valid && !redirect && !take;
    head      = skid_valid ? skid_entry : new_entry;

    out_next          = head;
    if (!take) begin
      out_next.instr    = BUBBLE_INSTR;
      out_next.next_pc  = pc;
      out_next.exc_code = EC_NONE;
      out_next.exc_addr = 32'h0;
    end

    state_next  = state;
    pc_next     = pc;
    squash_next = squash;
    if (redirect) begin
      pc_next = redirect_pc;
      if (imem_req && !imem_ready) begin
        state_next  = S_WAIT;
        squash_next = 1'b1;
      end else begin
        state_next  = S_REQ;
        squash_next = 1'b0;
      end
    end else if (take) begin
      pc_next    = pc + 32'd4;
      state_next = S_REQ;
    end else if (skid_load) begin
      state_next = S_HOLD;
    end else begin
      case (state)
        S_REQ:   if (imem_req) state_next = S_WAIT;
        S_WAIT: begin
          if (fetch_done) begin
            state_next  = S_REQ;
            squash_next = 1'b0;
          end
        end
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_REQ;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      squash   <= 1'b0;
      out_q    <= '{instr: BUBBLE_INSTR, next_pc: RESET_PC,
                    exc_code: EC_NONE, exc_addr: 32'h0};
    end else begin
      state  <= state_next;
      pc     <= pc_next;
      squash <= squash_next;
      if (state == S_REQ) req_addr <= pc;
      if (!stall) out_q <= out_next;
    end
  end

  assign interstage_if2id = out_q;
  assign debug_state      = state;

endmodule
